// File: rtl/tag_pkg.sv
// Shared widths, FSM state codes and entry field-slice helpers for the tag deconcat block.
package tag_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] UNPACK = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  function automatic int unsigned vw(input int unsigned size);
    return $clog2(size);
  endfunction

  function automatic int unsigned tw(input int unsigned k);
    return $clog2(k);
  endfunction

  function automatic int unsigned ew(input int unsigned size, input int unsigned k);
    return vw(size) + tw(k);
  endfunction

  // Entries are {tag, value}; callers pass the entry zero-extended to 32 bits.
  function automatic logic [31:0] entry_value(input logic [31:0] entry,
                                              input int unsigned vwid);
    return entry & ((32'd1 << vwid) - 32'd1);
  endfunction

  function automatic logic [31:0] entry_tag(input logic [31:0] entry,
                                            input int unsigned vwid,
                                            input int unsigned twid);
    return (entry >> vwid) & ((32'd1 << twid) - 32'd1);
  endfunction

endpackage

// File: rtl/tag_slot_bank.sv
// K lane registers with one tag-addressed write port, a synchronous clear, and (with
// TAG_CHECK_EN) a seen mask plus duplicate-write detect.
module tag_slot_bank
  import tag_pkg::*;
#(
  parameter int unsigned VW = 3,
  parameter int unsigned K  = 2,
  parameter int unsigned TW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_wr_en,
  input  logic [TW-1:0]     i_wr_tag,
  input  logic [VW-1:0]     i_wr_value,
  output logic [VW*K-1:0]   o_slots
`ifdef TAG_CHECK_EN
  ,
  output logic [K-1:0]      o_seen,
  output logic              o_dup
`endif
);

  logic [K-1:0][VW-1:0] r_slots;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slots <= '0;
    end else if (i_clr) begin
      r_slots <= '0;
    end else if (i_wr_en) begin
      r_slots[i_wr_tag] <= i_wr_value;
    end
  end

  assign o_slots = r_slots;

`ifdef TAG_CHECK_EN
  logic [K-1:0] r_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen <= '0;
    end else if (i_clr) begin
      r_seen <= '0;
    end else if (i_wr_en) begin
      r_seen[i_wr_tag] <= 1'b1;
    end
  end

  assign o_seen = r_seen;
  assign o_dup  = i_wr_en & r_seen[i_wr_tag];
`endif

endmodule

// File: rtl/tag_deconcat.sv
// Rebuilds K value lanes from a packed bus of {tag, value} entries, one entry per cycle.
// Optional macro TAG_CHECK_EN adds duplicate/missing/out-of-range tag reporting on o_err.
module tag_deconcat
  import tag_pkg::*;
#(
  parameter int unsigned SIZE = 8,
  parameter int unsigned K    = 2,
  localparam int unsigned VW  = vw(SIZE),
  localparam int unsigned TW  = tw(K),
  localparam int unsigned EW  = ew(SIZE, K)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [EW*K-1:0]   i_in,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [VW*K-1:0]   o_num_out,
  output logic              o_err,
  output logic              o_busy
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [EW*K-1:0]   r_in;
  logic [TW-1:0]     r_idx;
  logic [EW-1:0]     w_entry;
  logic [TW-1:0]     w_tag;
  logic [VW-1:0]     w_value;
  logic              w_tag_ok;
  logic              w_accept;
  logic              w_unpack;
  logic              w_wr_en;
  logic              w_last;
  logic              w_err;
  logic [VW*K-1:0]   w_slots;

  assign w_entry  = r_in[r_idx*EW +: EW];
  assign w_tag    = TW'(entry_tag(32'(w_entry), VW, TW));
  assign w_value  = VW'(entry_value(32'(w_entry), VW));
  // Only reachable as false when K is not a power of two.
  assign w_tag_ok = 32'(w_tag) < K;
  assign w_accept = i_in_valid && (r_state == IDLE);
  assign w_unpack = (r_state == UNPACK);
  assign w_wr_en  = w_unpack && w_tag_ok;
  assign w_last   = (r_idx == TW'(K - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_state_next = UNPACK;
      UNPACK:  if (w_last)      w_state_next = DONE;
      DONE:    if (i_out_ready) w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_in    <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_in  <= i_in;
        r_idx <= '0;
      end else if (w_unpack && !w_last) begin
        r_idx <= r_idx + TW'(1);
      end
    end
  end

`ifdef TAG_CHECK_EN
  logic [K-1:0] w_seen;
  logic         w_dup;
  logic         r_err;

  tag_slot_bank #(
    .VW (VW),
    .K  (K),
    .TW (TW)
  ) u_slot_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_accept),
    .i_wr_en    (w_wr_en),
    .i_wr_tag   (w_tag),
    .i_wr_value (w_value),
    .o_slots    (w_slots),
    .o_seen     (w_seen),
    .o_dup      (w_dup)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_unpack && (!w_tag_ok || w_dup)) begin
      r_err <= 1'b1;
    end
  end

  // A lane nobody wrote is as much an error as a lane written twice.
  assign w_err = r_err | ~&w_seen;
`else
  tag_slot_bank #(
    .VW (VW),
    .K  (K),
    .TW (TW)
  ) u_slot_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_accept),
    .i_wr_en    (w_wr_en),
    .i_wr_tag   (w_tag),
    .i_wr_value (w_value),
    .o_slots    (w_slots)
  );

  assign w_err = 1'b0;
`endif

  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = (r_state == DONE);
  assign o_busy      = (r_state == UNPACK) || (r_state == DONE);
  assign o_num_out   = o_out_valid ? w_slots : '0;
  assign o_err       = o_out_valid & w_err;

endmodule

// File: tb/tb_tag_deconcat.sv
// Self-checking bench: two tag_deconcat instances (K=2/SIZE=8 and K=4/SIZE=16) against a
// lane/count reference model.
module tb_tag_deconcat;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err, a_busy;
  logic [7:0]  a_in;
  logic [5:0]  a_num;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err, b_busy;
  logic [23:0] b_in;
  logic [15:0] b_num;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef TAG_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  tag_deconcat #(.SIZE(8), .K(2)) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (a_in_valid),
    .o_in_ready  (a_in_ready),
    .i_in        (a_in),
    .o_out_valid (a_out_valid),
    .i_out_ready (a_out_ready),
    .o_num_out   (a_num),
    .o_err       (a_err),
    .o_busy      (a_busy)
  );

  tag_deconcat #(.SIZE(16), .K(4)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (b_in_valid),
    .o_in_ready  (b_in_ready),
    .i_in        (b_in),
    .o_out_valid (b_out_valid),
    .i_out_ready (b_out_ready),
    .o_num_out   (b_num),
    .o_err       (b_err),
    .o_busy      (b_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk entries in bus order, last write wins, count writes per lane.
  function automatic void model(input logic [63:0] bus, input int k, input int vwid,
                                input int twid, output logic [63:0] num, output logic e);
    int lane[8];
    int cnt[8];
    bit bad;
    int ewid;
    bad  = 1'b0;
    ewid = vwid + twid;
    for (int t = 0; t < 8; t++) begin
      lane[t] = 0;
      cnt[t]  = 0;
    end
    for (int i = 0; i < k; i++) begin
      int tg;
      int vl;
      tg = int'((bus >> (i * ewid + vwid)) & ((64'd1 << twid) - 64'd1));
      vl = int'((bus >> (i * ewid)) & ((64'd1 << vwid) - 64'd1));
      if (tg < k) begin
        lane[tg] = vl;
        cnt[tg]++;
      end else begin
        bad = 1'b1;
      end
    end
    num = '0;
    for (int t = 0; t < k; t++) begin
      num = num | (64'(lane[t]) << (t * vwid));
      if (cnt[t] != 1) bad = 1'b1;
    end
    e = CHK && bad;
  endfunction

  function automatic logic [63:0] obs_num(input int w);
    return (w == 0) ? 64'(a_num) : 64'(b_num);
  endfunction
  function automatic logic obs_ov(input int w);
    return (w == 0) ? a_out_valid : b_out_valid;
  endfunction
  function automatic logic obs_ir(input int w);
    return (w == 0) ? a_in_ready : b_in_ready;
  endfunction
  function automatic logic obs_err(input int w);
    return (w == 0) ? a_err : b_err;
  endfunction
  function automatic logic obs_busy(input int w);
    return (w == 0) ? a_busy : b_busy;
  endfunction

  task automatic set_in(input int w, input logic [63:0] bus, input logic v);
    if (w == 0) begin
      a_in       = bus[7:0];
      a_in_valid = v;
    end else begin
      b_in       = bus[23:0];
      b_in_valid = v;
    end
  endtask

  task automatic set_or(input int w, input logic v);
    if (w == 0) a_out_ready = v;
    else        b_out_ready = v;
  endtask

  // One full transaction; hold = cycles of out_ready=0 in DONE with a competing in_valid.
  task automatic txn(input int w, input logic [63:0] bus, input int hold, input bit pre_ready,
                     input string tag);
    int k;
    int lat;
    logic [63:0] exp_num;
    logic exp_err;
    k = (w == 0) ? 2 : 4;
    model(bus, k, (w == 0) ? 3 : 4, (w == 0) ? 1 : 2, exp_num, exp_err);
    @(negedge clk);
    check({tag, " in_ready_idle"}, 64'(obs_ir(w)), 64'd1);
    set_in(w, bus, 1'b1);
    set_or(w, pre_ready);
    @(negedge clk);
    set_in(w, bus, 1'b0);
    lat = 0;
    while (!obs_ov(w) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(k));
    check({tag, " num_out"}, obs_num(w), exp_num);
    check({tag, " err"}, 64'(obs_err(w)), 64'(exp_err));
    check({tag, " busy_done"}, 64'(obs_busy(w)), 64'd1);
    check({tag, " in_ready_done"}, 64'(obs_ir(w)), 64'd0);
    for (int h = 0; h < hold; h++) begin
      set_in(w, ~bus, 1'b1);
      @(negedge clk);
      check({tag, " hold_valid"}, 64'(obs_ov(w)), 64'd1);
      check({tag, " hold_num"}, obs_num(w), exp_num);
      check({tag, " hold_err"}, 64'(obs_err(w)), 64'(exp_err));
      check({tag, " hold_in_ready"}, 64'(obs_ir(w)), 64'd0);
    end
    set_or(w, 1'b1);
    @(negedge clk);
    set_in(w, bus, 1'b0);
    set_or(w, 1'b0);
    check({tag, " in_ready_after"}, 64'(obs_ir(w)), 64'd1);
    check({tag, " out_valid_after"}, 64'(obs_ov(w)), 64'd0);
    check({tag, " busy_after"}, 64'(obs_busy(w)), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] bus;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in = '0;

    #1;
    check("reset a in_ready", 64'(a_in_ready), 64'd1);
    check("reset a out_valid", 64'(a_out_valid), 64'd0);
    check("reset a num_out", 64'(a_num), 64'd0);
    check("reset a err", 64'(a_err), 64'd0);
    check("reset a busy", 64'(a_busy), 64'd0);
    check("reset b in_ready", 64'(b_in_ready), 64'd1);
    check("reset b num_out", 64'(b_num), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    txn(0, 64'hE5, 0, 1'b0, "ordered");
    txn(0, 64'h6D, 0, 1'b0, "swapped");
    txn(0, 64'h53, 0, 1'b0, "dup_tag");
    txn(0, 64'hE5, 5, 1'b0, "backpressure");

    // Abort mid-UNPACK on the K=4 instance.
    bus = 64'({2'd0, 4'hA, 2'd1, 4'h3, 2'd2, 4'h7, 2'd3, 4'hC});
    @(negedge clk);
    set_in(1, bus, 1'b1);
    @(negedge clk);
    set_in(1, bus, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset in_ready", 64'(b_in_ready), 64'd1);
    check("midreset out_valid", 64'(b_out_valid), 64'd0);
    check("midreset num_out", 64'(b_num), 64'd0);
    check("midreset busy", 64'(b_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1, bus, 0, 1'b0, "after_reset");

    txn(1, 64'({2'd3, 4'h1, 2'd0, 4'hF, 2'd2, 4'h8, 2'd1, 4'h6}), 0, 1'b1, "b2b_1");
    txn(1, 64'({2'd1, 4'h9, 2'd3, 4'h2, 2'd0, 4'h4, 2'd2, 4'hE}), 0, 1'b1, "b2b_2");
    txn(1, 64'({2'd2, 4'h5, 2'd2, 4'hB, 2'd0, 4'h1, 2'd1, 4'h0}), 2, 1'b0, "b_dup_missing");

    for (int r = 0; r < 16; r++) begin
      int w;
      w   = int'($urandom_range(0, 1));
      bus = {32'($urandom), 32'($urandom)};
      txn(w, bus, int'($urandom_range(0, 3)), 1'b0, (w == 0) ? "rand_a" : "rand_b");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_deconcat.md
Name: tag_deconcat

Overview:
- Inverse of the tag-concatenation stage: accepts a packed bus of K tagged entries, each {tag, value}, and rebuilds the K-lane value vector with each value placed in the lane named by its tag.
- Sits downstream of the concat stage. Restores generator-order lanes regardless of the order in which entries arrive on the bus.
- Sequential design: captures the bus once, unpacks one entry per cycle through an FSM, then presents the result on a valid/ready output handshake.

Parameters:
- SIZE, 8, value range; value width VW = $clog2(SIZE).
- K, 2, number of entries/lanes; K >= 2; tag width TW = $clog2(K).
- EW, derived localparam = VW + TW, entry width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input bus valid.
- in_ready  out  1  block can capture input.
- in  in  EW*K  packed entries; entry i = in[i*EW +: EW]; tag = upper TW bits, value = lower VW bits.
- out_valid  out  1  num_out/err valid.
- out_ready  in  1  consumer accepts result.
- num_out  out  VW*K  rebuilt lanes; lane t = num_out[t*VW +: VW].
- err  out  1  tag error for current result (qualified by out_valid).
- busy  out  1  high in UNPACK or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; capture register, slots, seen mask, index and error flag all cleared.
  - Outputs: in_ready=1, out_valid=0, num_out=0, err=0, busy=0.
  - Reset asserted mid-UNPACK or mid-DONE aborts the transaction; no output is produced.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture the whole bus, clear slots and the seen mask, idx=0, error flag=0, go to UNPACK.
- UNPACK (in_ready=0): each cycle, process entry idx.
  - tag < K and seen[tag]=0: slot[tag]<=value; seen[tag]<=1.
  - tag < K and seen[tag]=1: slot[tag]<=value (last write wins); set error flag.
  - tag >= K (only possible when K is not a power of 2): no write; set error flag.
  - idx==K-1: go to DONE; otherwise idx++.
- DONE:
  - out_valid=1; num_out driven from the slots.
  - err = error flag OR any seen bit still 0. Slots never written read 0.
  - Outputs are held stable while out_ready=0.
  - On out_ready: go to IDLE.
- Latency: input handshake at edge N gives out_valid=1 after edge N+K. Minimum throughput is one result per K+2 cycles.
- No input is accepted while busy; in_valid in that period is ignored and the input stays pending upstream.
- Tag and value extraction are pure bit slicing; no arithmetic on values.

Optional Feature:
- Macro: TAG_CHECK_EN.
- Defined: the seen mask and error flag are implemented; err behaves as above.
- Undefined: no seen mask or flag logic; err tied 0. Duplicate tags still overwrite (last wins). Tags >= K are still dropped.

Decomposition:
- Shared package tag_pkg holds:
  - width functions vw(SIZE), tw(K), ew(SIZE,K);
  - state enum {IDLE, UNPACK, DONE};
  - entry field-slice helper functions.
- One natural sub-module, tag_slot_bank: K×VW registers with a write port (en, tag, value), a clear input, the seen mask, and a duplicate-detect output.

Test Plan:
- Ordered tags (K=2, SIZE=8, EW=4): in=8'hE5, i.e. entry0={0,5}, entry1={1,6}. Required: num_out=6'h35, err=0, out_valid 2 cycles after the handshake edge.
- Swapped tags: in=8'h6D, i.e. entry0={1,5}, entry1={0,6}. Required: num_out=6'h2E (lane0=6, lane1=5), err=0.
- Duplicate tag: in=8'h53, i.e. both entries tag 0, values 3 then 5. Required: num_out=6'h05, err=1 with TAG_CHECK_EN defined; err=0 without it.
- Backpressure: out_ready=0 for 5 cycles in DONE. Required: out_valid, num_out and err held stable; in_ready=0; a new in_valid is not captured until out_ready handshakes.
- Reset mid-UNPACK (K=4, SIZE=16): pulse rst_n low after the first unpack cycle. Required: immediate in_ready=1, out_valid=0, num_out=0; the next transaction returns correct lanes.
- Back-to-back (K=4): two transactions with out_ready held 1. Required: second result is correct, and in_ready returns to 1 exactly one cycle after each output handshake.
